// File: rtl/spart_bus_master.sv
// rtl/spart_bus_master.sv - SPART bus master: programs the divisor, then transmits and reads back NUM_BYTES bytes.
// The optional WAIT_RDA timeout is enabled by defining SPART_MASTER_TIMEOUT_EN.
module spart_bus_master #(
  parameter int unsigned NUM_BYTES = 4,
  parameter logic [15:0] DIVISOR   = 16'h9600,
  parameter logic [7:0]  SEED      = 8'h45,
  parameter logic [23:0] TIMEOUT   = 24'd1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] rx_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DBL, S_WR_DBH, S_WAIT_TBR, S_WR_TX, S_WAIT_RDA, S_RD_RX, S_DONE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_iocs, r_iorw, r_oe, r_busy, r_done;
  logic [1:0] r_ioaddr;
  logic [7:0] r_dout, r_idx, r_err, r_rx;
  logic       w_last, w_start, w_advance, w_mismatch, w_tmo_hit;
  logic [7:0] w_exp;

  assign w_last  = (r_idx == LAST_IDX);
  assign w_exp   = SEED + r_idx;
  assign w_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef SPART_MASTER_TIMEOUT_EN
  logic [23:0] r_tmo;
  assign w_tmo_hit = (r_state == S_WAIT_RDA) && !rda && (r_tmo == TIMEOUT - 24'd1);
`else
  assign w_tmo_hit = 1'b0;
`endif

  // A byte is finished either by a read-back or by a timeout; a timeout counts as an error.
  assign w_advance  = (r_state == S_RD_RX) || w_tmo_hit;
  assign w_mismatch = ((r_state == S_RD_RX) && (databus != w_exp)) || w_tmo_hit;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_WR_DBL;
      S_WR_DBL:       w_next = S_WR_DBH;
      S_WR_DBH:       w_next = S_WAIT_TBR;
      S_WAIT_TBR:     if (tbr) w_next = S_WR_TX;
      S_WR_TX:        w_next = S_WAIT_RDA;
      S_WAIT_RDA: begin
        if (rda)            w_next = S_RD_RX;
        else if (w_tmo_hit) w_next = w_last ? S_DONE : S_WAIT_TBR;
      end
      S_RD_RX:        w_next = w_last ? S_DONE : S_WAIT_TBR;
      default:        w_next = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so each access lines up with its state cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_iocs   <= 1'b0;
      r_iorw   <= 1'b1;
      r_oe     <= 1'b0;
      r_ioaddr <= 2'b00;
      r_dout   <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_idx    <= 8'h00;
      r_err    <= 8'h00;
      r_rx     <= 8'h00;
    end else begin
      r_state  <= w_next;
      r_iocs   <= (w_next == S_WR_DBL) || (w_next == S_WR_DBH) ||
                  (w_next == S_WR_TX)  || (w_next == S_RD_RX);
      r_iorw   <= !((w_next == S_WR_DBL) || (w_next == S_WR_DBH) || (w_next == S_WR_TX));
      r_oe     <= (w_next == S_WR_DBL) || (w_next == S_WR_DBH) || (w_next == S_WR_TX);
      r_busy   <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_done   <= (w_next == S_DONE);
      case (w_next)
        S_WR_DBL: begin r_ioaddr <= 2'b10; r_dout <= DIVISOR[7:0];  end
        S_WR_DBH: begin r_ioaddr <= 2'b11; r_dout <= DIVISOR[15:8]; end
        S_WR_TX:  begin r_ioaddr <= 2'b00; r_dout <= w_exp;         end
        default:  begin r_ioaddr <= 2'b00; r_dout <= 8'h00;         end
      endcase
      if (w_start) begin
        r_idx <= 8'h00;
        r_err <= 8'h00;
        r_rx  <= 8'h00;
      end else begin
        if (w_advance && !w_last)            r_idx <= r_idx + 8'd1;
        if (r_state == S_RD_RX)              r_rx  <= r_rx + 8'd1;
        if (w_mismatch && (r_err != 8'hFF))  r_err <= r_err + 8'd1;
      end
    end
  end

`ifdef SPART_MASTER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_tmo <= 24'd0;
    else if ((r_state == S_WAIT_RDA) && !rda && !w_tmo_hit)
      r_tmo <= r_tmo + 24'd1;
    else
      r_tmo <= 24'd0;
  end
`endif

  assign databus   = r_oe ? r_dout : 8'hzz;
  assign iocs      = r_iocs;
  assign iorw      = r_iorw;
  assign ioaddr    = r_ioaddr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_done && (r_err == 8'h00);
  assign err_count = r_err;
  assign rx_count  = r_rx;

endmodule

// File: tb/tb_spart_bus_master.sv
// tb/tb_spart_bus_master.sv - self-checking bench for spart_bus_master with an echo SPART responder.
module tb_spart_bus_master;

  localparam logic [15:0] DIV  = 16'h9600;
  localparam logic [7:0]  SEED = 8'h45;
  localparam int          NB   = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, rda, tbr;
  logic       iocs, iorw, busy, done, pass;
  logic [1:0] ioaddr;
  logic [7:0] err_count, rx_count;
  wire  [7:0] databus;

  logic       tb_probe = 1'b0;
  logic [7:0] probe_val = 8'h00;
  logic [7:0] pend = 8'h00;
  logic       rda_en = 1'b1;
  logic [3:0] cfg_mask = 4'h0;
  logic [7:0] cfg_xor = 8'h00;
  int         run_gen = 0;
  logic [9:0] wlog[$];

  int n_tests = 0;
  int n_fail  = 0;

  assign databus = ((iocs && iorw && (ioaddr == 2'b00)) || tb_probe) ?
                   (tb_probe ? probe_val : pend) : 8'hzz;

  spart_bus_master #(.NUM_BYTES(NB), .DIVISOR(DIV), .SEED(SEED), .TIMEOUT(24'd1000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .rx_count(rx_count));

  always #5 clk = ~clk;

  // Echo responder: logs every write, returns each TX byte (optionally corrupted) after a random delay.
  initial begin
    int seen = 0;
    int dly = 0;
    int my_gen = 0;
    logic pending = 1'b0;
    rda = 1'b0;
    tbr = 1'b0;
    forever begin
      @(negedge clk);
      if (my_gen != run_gen) begin
        my_gen = run_gen;
        seen = 0;
        pending = 1'b0;
        rda = 1'b0;
      end
      if (iocs && !iorw) begin
        wlog.push_back({ioaddr, databus});
        if (ioaddr == 2'b00) begin
          pend = databus ^ ((seen < 4 && cfg_mask[seen[1:0]]) ? cfg_xor : 8'h00);
          seen++;
          dly = $urandom_range(0, 4);
          pending = 1'b1;
        end
      end else if (iocs && iorw && ioaddr == 2'b00) begin
        rda = 1'b0;
        pending = 1'b0;
      end else if (pending && rda_en) begin
        if (dly == 0) rda = 1'b1;
        else dly--;
      end
      tbr = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: done never rose within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_log(input int len, input int budget);
    int k = 0;
    while (wlog.size() < len && k < budget) begin @(negedge clk); k++; end
    if (wlog.size() < len) begin
      n_tests++; n_fail++;
      $display("FAIL log_wait: %0d writes seen, wanted %0d", wlog.size(), len);
    end
  endtask

  // Reference: divisor low, divisor high, then SEED+i for each byte.
  task automatic check_log(input string name);
    logic [9:0] exp_q[$];
    exp_q.push_back({2'b10, DIV[7:0]});
    exp_q.push_back({2'b11, DIV[15:8]});
    for (int i = 0; i < NB; i++) exp_q.push_back({2'b00, 8'(SEED + i)});
    chk({name, "_nwrites"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      chk($sformatf("%s_wr%0d", name, i), {22'd0, wlog[i]}, {22'd0, exp_q[i]});
  endtask

  task automatic do_run(input string name, input logic [3:0] mask, input logic [7:0] xv,
                        input logic [7:0] exp_err, input logic exp_pass);
    cfg_mask = mask;
    cfg_xor = xv;
    run_gen++;
    wlog.delete();
    pulse_start();
    wait_done(name, 3000);
    chk({name, "_done"}, done, 1);
    chk({name, "_pass"}, pass, exp_pass);
    chk({name, "_err"}, err_count, exp_err);
    chk({name, "_rx"}, rx_count, NB);
    check_log(name);
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [7:0] xv;
    logic [7:0] exp_err;
    logic       exp_pass;
  } vec_t;

  initial begin
    vec_t vecs[4];
    vecs[0] = '{4'b0000, 8'h00, 8'd0, 1'b1};
    vecs[1] = '{4'b0010, 8'h80, 8'd1, 1'b0};
    vecs[2] = '{4'b1111, 8'h01, 8'd4, 1'b0};
    vecs[3] = '{4'b1001, 8'hFF, 8'd2, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_iocs", iocs, 0);
    chk("rst_iorw", iorw, 1);
    chk("rst_ioaddr", ioaddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_rx", rx_count, 0);
    probe_val = 8'h00; tb_probe = 1'b1; #1;
    chk("rst_bus_released", databus, 8'h00);
    tb_probe = 1'b0;
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++)
      do_run($sformatf("vec%0d", v), vecs[v].mask, vecs[v].xv, vecs[v].exp_err, vecs[v].exp_pass);

    for (int r = 0; r < 6; r++) begin
      logic [3:0] m;
      logic [7:0] xv;
      int e;
      m  = 4'($urandom_range(0, 15));
      xv = 8'($urandom_range(1, 255));
      e  = 0;
      for (int i = 0; i < NB; i++) if (m[i]) e++;
      do_run($sformatf("rnd%0d", r), m, xv, 8'(e), (e == 0));
    end

    // start while busy must not restart the run
    cfg_mask = 4'b0000; run_gen++; wlog.delete();
    pulse_start();
    wait_log(3, 200);
    chk("busy_mid", busy, 1);
    pulse_start();
    wait_done("busy_start", 3000);
    chk("busy_start_pass", pass, 1);
    check_log("busy_start");

    // start in DONE restarts with cleared counts and a WR_DBL cycle
    cfg_mask = 4'b0100; cfg_xor = 8'h10; run_gen++; wlog.delete();
    pulse_start();
    wait_done("pre_restart", 3000);
    chk("pre_restart_err", err_count, 1);
    cfg_mask = 4'b0000; run_gen++; wlog.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("restart_iocs", iocs, 1);
    chk("restart_iorw", iorw, 0);
    chk("restart_ioaddr", ioaddr, 2'b10);
    chk("restart_data", databus, DIV[7:0]);
    chk("restart_done", done, 0);
    chk("restart_err", err_count, 0);
    chk("restart_rx", rx_count, 0);
    wait_done("restart", 3000);
    chk("restart_pass", pass, 1);

    // reset while parked in WAIT_RDA
    rda_en = 1'b0; run_gen++; wlog.delete();
    pulse_start();
    wait_log(3, 200);
    repeat (3) @(negedge clk);
    chk("wrda_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_iocs", iocs, 0);
    chk("midrst_iorw", iorw, 1);
    probe_val = 8'h00; tb_probe = 1'b1; #1;
    chk("midrst_bus_released", databus, 8'h00);
    tb_probe = 1'b0;
    rst_n = 1'b1;
    rda_en = 1'b1;
    do_run("post_rst", 4'b0000, 8'h00, 8'd0, 1'b1);

`ifdef SPART_MASTER_TIMEOUT_EN
    rda_en = 1'b0; cfg_mask = 4'b0000; run_gen++; wlog.delete();
    pulse_start();
    wait_done("tmo", 10000);
    chk("tmo_done", done, 1);
    chk("tmo_err", err_count, 4);
    chk("tmo_rx", rx_count, 0);
    chk("tmo_pass", pass, 0);
    check_log("tmo");
    rda_en = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
